// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//   state_e   : controller FSM state encoding (IDLE=0, RUN=1, DONE=2).
//   cnt_width : bit-counter width, clog2(max(width, 2)).
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned v;
    int unsigned r;
    v = ((width < 2) ? 2 : width) - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
//   Request side : in_valid, in_ready, a, b, c_in
//   Result side  : out_valid, out_ready, sum, c_out
//   Status       : busy
// modport slave  : the adder engine.
// modport master : the requester (hash round controller / bench).
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// One-bit full-adder cell; the whole datapath of the serial adder.
//   a_i, b_i, c_i : addend bits and carry-in
//   sum_o, c_o    : sum bit and carry-out
module serial_add_ctrl_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic c_o
);

  assign sum_o = a_i ^ b_i ^ c_i;
  assign c_o   = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts two WIDTH-bit operands plus carry-in,
// feeds one full-adder cell LSB-first over WIDTH cycles, and returns the
// WIDTH-bit sum (mod 2^WIDTH) with the final carry-out.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : request/result handshake (slave side), see serial_add_ctrl_if
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q, c_out_q;
  logic [CntW-1:0]  cnt_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic [WIDTH:0]   sum_shift;
  logic             unused_sum_lsb;

  serial_add_ctrl_full_adder u_fa (
    .a_i  (a_sr_q[0]),
    .b_i  (b_sr_q[0]),
    .c_i  (carry_q),
    .sum_o(fa_sum),
    .c_o  (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  // Built through a WIDTH+1 vector so WIDTH=1 needs no special case.
  always_comb begin
    sum_shift      = {fa_sum, sum_sr_q};
    sum_sr_d       = sum_shift[WIDTH:1];
    unused_sum_lsb = sum_shift[0];
    last_bit       = (cnt_q == CntW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      sum_sr_q    <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // in_ready_q is high throughout IDLE, so in_valid alone accepts.
          if (bus.in_valid) begin
            a_sr_q     <= bus.a;
            b_sr_q     <= bus.b;
            carry_q    <= bus.c_in;
            cnt_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          sum_sr_q <= sum_sr_d;
          carry_q  <= fa_cout;
          if (last_bit) begin
            // Separate result registers keep sum/c_out stable across the
            // next operation's RUN phase.
            sum_q       <= sum_sr_d;
            c_out_q     <= fa_cout;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(32)) bus32 ();
  serial_add_ctrl_if #(.WIDTH(1))  bus1 ();

  serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(bus32.slave)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [32:0] sb32[$];
  logic [1:0]  sb1[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({bus32.in_ready, bus32.out_valid, bus32.busy} !== 3'b100) begin
      bad++;
      $display("FAIL reset32 flags: got %b want 100",
               {bus32.in_ready, bus32.out_valid, bus32.busy});
    end
    total++;
    if ({bus32.c_out, bus32.sum} !== 33'h0) begin
      bad++;
      $display("FAIL reset32 result: got %h want 0", {bus32.c_out, bus32.sum});
    end
    total++;
    if ({bus1.in_ready, bus1.out_valid, bus1.busy, bus1.c_out, bus1.sum} !== 5'b10000) begin
      bad++;
      $display("FAIL reset1 outputs: got %b want 10000",
               {bus1.in_ready, bus1.out_valid, bus1.busy, bus1.c_out, bus1.sum});
    end
  endtask

  task automatic test_add32(input logic [31:0] a, input logic [31:0] b, input logic c,
                            input string name);
    int   lat;
    logic ready_seen;
    logic [32:0] exp;
    bus32.a        = a;
    bus32.b        = b;
    bus32.c_in     = c;
    bus32.in_valid = 1'b1;
    tick();
    sb32.push_back({1'b0, a} + {1'b0, b} + {32'd0, c});
    bus32.in_valid = 1'b0;
    total++;
    if ({bus32.in_ready, bus32.busy, bus32.out_valid} !== 3'b010) begin
      bad++;
      $display("FAIL %s accept flags: got %b want 010", name,
               {bus32.in_ready, bus32.busy, bus32.out_valid});
    end
    lat = 0;
    ready_seen = 1'b0;
    while (bus32.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (bus32.in_ready !== 1'b0) ready_seen = 1'b1;
    end
    total++;
    if (lat != 32) begin
      bad++;
      $display("FAIL %s latency: got %0d want 32", name, lat);
    end
    total++;
    if (ready_seen !== 1'b0) begin
      bad++;
      $display("FAIL %s in_ready during op: got 1 want 0", name);
    end
    exp = sb32.pop_front();
    total++;
    if ({bus32.c_out, bus32.sum} !== exp) begin
      bad++;
      $display("FAIL %s result: got %h want %h", name, {bus32.c_out, bus32.sum}, exp);
    end
    bus32.out_ready = 1'b1;
    tick();
    bus32.out_ready = 1'b0;
    total++;
    if ({bus32.in_ready, bus32.out_valid, bus32.busy} !== 3'b100) begin
      bad++;
      $display("FAIL %s post-handshake flags: got %b want 100", name,
               {bus32.in_ready, bus32.out_valid, bus32.busy});
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic [32:0] exp;
    bus32.a        = 32'hDEADBEEF;
    bus32.b        = 32'h11111111;
    bus32.c_in     = 1'b1;
    bus32.in_valid = 1'b1;
    tick();
    sb32.push_back({1'b0, 32'hDEADBEEF} + {1'b0, 32'h11111111} + 33'd1);
    // Junk requests during RUN must be ignored.
    bus32.a    = 32'hFFFFFFFF;
    bus32.b    = 32'hFFFFFFFF;
    bus32.c_in = 1'b1;
    lat = 0;
    while (bus32.out_valid !== 1'b1 && lat < 40) begin
      bus32.in_valid = lat[0];
      tick();
      lat++;
    end
    total++;
    if (lat != 32) begin
      bad++;
      $display("FAIL bp latency: got %0d want 32", lat);
    end
    exp = sb32.pop_front();
    bus32.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0 ||
          {bus32.c_out, bus32.sum} !== exp) begin
        bad++;
        $display("FAIL bp hold cycle %0d: got v=%b r=%b res=%h want v=1 r=0 res=%h", i,
                 bus32.out_valid, bus32.in_ready, {bus32.c_out, bus32.sum}, exp);
      end
    end
    bus32.out_ready = 1'b1;
    total++;
    if (bus32.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp no-bypass in_ready: got %b want 0", bus32.in_ready);
    end
    tick();
    bus32.in_valid  = 1'b0;
    bus32.out_ready = 1'b0;
    tick();
    total++;
    if ({bus32.in_ready, bus32.out_valid, bus32.busy} !== 3'b100) begin
      bad++;
      $display("FAIL bp idle after handshake: got %b want 100",
               {bus32.in_ready, bus32.out_valid, bus32.busy});
    end
    test_add32(32'd3, 32'd5, 1'b0, "after_bp 3+5");
  endtask

  task automatic test_reset_mid();
    logic seen_valid;
    bus32.a        = 32'h0F0F0F0F;
    bus32.b        = 32'h01010101;
    bus32.c_in     = 1'b0;
    bus32.in_valid = 1'b1;
    tick();
    sb32.push_back({1'b0, 32'h0F0F0F0F} + {1'b0, 32'h01010101});
    bus32.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb32.delete();
    total++;
    if ({bus32.in_ready, bus32.out_valid, bus32.busy} !== 3'b100) begin
      bad++;
      $display("FAIL midreset flags: got %b want 100",
               {bus32.in_ready, bus32.out_valid, bus32.busy});
    end
    total++;
    if ({bus32.c_out, bus32.sum} !== 33'h0) begin
      bad++;
      $display("FAIL midreset result: got %h want 0", {bus32.c_out, bus32.sum});
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus32.out_valid !== 1'b0) seen_valid = 1'b1;
    end
    total++;
    if (seen_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset stray out_valid: got 1 want 0");
    end
    test_add32(32'h80000000, 32'h80000000, 1'b0, "after_reset 8000+8000");
  endtask

  task automatic test_width1();
    int   lat;
    logic [2:0] v;
    logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      bus1.a        = v[2];
      bus1.b        = v[1];
      bus1.c_in     = v[0];
      bus1.in_valid = 1'b1;
      tick();
      sb1.push_back({1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]});
      bus1.in_valid = 1'b0;
      lat = 0;
      while (bus1.out_valid !== 1'b1 && lat < 5) begin
        tick();
        lat++;
      end
      total++;
      if (lat != 1) begin
        bad++;
        $display("FAIL w1 latency abc=%b: got %0d want 1", v, lat);
      end
      exp = sb1.pop_front();
      total++;
      if ({bus1.c_out, bus1.sum} !== exp) begin
        bad++;
        $display("FAIL w1 result abc=%b: got %b want %b", v, {bus1.c_out, bus1.sum}, exp);
      end
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      total++;
      if (bus1.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL w1 idle abc=%b: got in_ready=%b want 1", v, bus1.in_ready);
      end
    end
  endtask

  initial begin
    bus32.in_valid  = 1'b0;
    bus32.a         = '0;
    bus32.b         = '0;
    bus32.c_in      = 1'b0;
    bus32.out_ready = 1'b0;
    bus1.in_valid   = 1'b0;
    bus1.a          = '0;
    bus1.b          = '0;
    bus1.c_in       = 1'b0;
    bus1.out_ready  = 1'b0;

    test_reset();
    test_add32(32'h00000000, 32'h00000000, 1'b0, "zero");
    test_add32(32'hFFFFFFFF, 32'h00000001, 1'b0, "ripple");
    test_add32(32'h12345678, 32'h9ABCDEF0, 1'b1, "mixed_cin");
    total++;
    if ((32'h12345678 + 32'h9ABCDEF0 + 32'd1) !== 32'hACF13569 || bus32.sum !== 32'hACF13569) begin
      bad++;
      $display("FAIL mixed_cin held sum: got %h want acf13569", bus32.sum);
    end
    test_backpressure();
    test_reset_mid();
    test_width1();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder sequencer: accepts two WIDTH-bit operands plus carry-in.
- Drives a single one-bit full-adder cell LSB-first over WIDTH cycles.
- Returns the WIDTH-bit sum and final carry-out.
- Area-minimal modular-add engine (mod 2^WIDTH, e.g. 32-bit hash word additions); sits between the hash round controller and its operand registers, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand/sum width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A; sampled only on acceptance.
- b  input  WIDTH  operand B; sampled only on acceptance.
- c_in  input  1  carry-in; sampled only on acceptance.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered sum (a+b+c_in) mod 2^WIDTH.
- c_out  output  1  registered carry out of bit WIDTH-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: synchronous, sampled on a clk edge with rst=1. Next state IDLE; a_sr, b_sr, sum_sr, carry and bit counter all cleared.
- Outputs after reset: in_ready=1, out_valid=0, busy=0, sum=0, c_out=0. Reset overrides every other input in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance = in_valid & in_ready at an edge.
  - On acceptance: a_sr<=a, b_sr<=b, carry<=c_in, cnt<=0, go RUN.
  - in_valid=0: stay IDLE, no register change.
- RUN (in_ready=0, busy=1), each cycle:
  - full-adder inputs = a_sr[0], b_sr[0], carry.
  - sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr logical-shift right by 1.
  - carry <= fa_cout.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 at the edge, go DONE.
  - in_valid is ignored while in RUN.
- DONE:
  - out_valid=1; sum=sum_sr; c_out=carry.
  - Both outputs held stable while out_ready=0 (unbounded backpressure).
  - out_valid & out_ready at an edge: go IDLE.
  - sum/c_out keep their last value until the next RUN completes.
- Latency: acceptance at edge k -> out_valid high from edge k+WIDTH. Throughput is one operation per WIDTH+2 cycles minimum (the IDLE acceptance cycle is not overlapped with DONE).
- No bypass: in_ready stays 0 in DONE, even when out_ready=1 in the same cycle.
- Counter width: clog2(max(WIDTH,2)); no wrap beyond WIDTH-1.
- WIDTH=1: exactly one RUN cycle.
- Carry: c_out is the true carry; overflow is not flagged separately.
- Reset mid-RUN or mid-DONE: operation abandoned, no out_valid pulse, returns to IDLE the next cycle.
- Illegal state encoding: next state IDLE.

Decomposition:
- Shared header serial_add_defs:
  - state localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - clog2 constant function for the counter width.
- One sub-module: instantiate the team's existing one-bit full_adder cell (a, b, c_in -> sum, c_out) as the datapath.
- The FSM, shift registers and carry flop live in serial_add_ctrl.

Test Plan:
- Zero add, WIDTH=32: a=0, b=0, c_in=0 accepted at edge k -> out_valid rises at edge k+32; sum=0x00000000, c_out=0; in_ready=0 from k+1 until DONE handshake.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, c_in=0 -> sum=0x00000000, c_out=1.
- Mixed with carry-in: a=0x12345678, b=0x9ABCDEF0, c_in=1 -> sum=0xACF13569, c_out=0.
- Backpressure and ignored requests:
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1; sum/c_out unchanged.
  - Pulse in_valid with new operands during RUN and DONE -> ignored.
  - After out_ready=1 -> IDLE next cycle; the following op with a=3, b=5, c_in=0 yields sum=8.
- Reset mid-op: assert rst for one cycle at RUN cycle 10 -> next cycle in_ready=1, out_valid=0, busy=0, sum=0. A subsequent a=0x80000000, b=0x80000000 yields sum=0, c_out=1.
- WIDTH=1 exhaustive: all 8 (a,b,c_in) combos -> {c_out,sum} equals a+b+c_in; out_valid one cycle after acceptance.
